// File: rtl/jump_pkg.sv
// Shared types and constants for the jump/branch issue controller.
package jump_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [2:0] CMP_BEQ  = 3'd0;
    localparam logic [2:0] CMP_BNE  = 3'd1;
    localparam logic [2:0] CMP_BLT  = 3'd2;
    localparam logic [2:0] CMP_BGE  = 3'd3;
    localparam logic [2:0] CMP_BLTU = 3'd4;
    localparam logic [2:0] CMP_BGEU = 3'd5;

    localparam int TIMEOUT_DEFAULT = 15;

    // JALR targets are halfword-aligned by clearing the low bit.
    function automatic logic [31:0] clr_bit0(input logic [31:0] a);
        return {a[31:1], 1'b0};
    endfunction

endpackage

// File: rtl/jump_ctrl.sv
// Issue-side controller for the jump FU: holds one instruction, pulses fu_en, resolves redirect/link.
// Latency: issue-to-redirect 3 cycles with a 1-cycle FU; one instruction every 4 cycles.
// Backpressure: issue_ready only in IDLE; FU stalls bounded by a TIMEOUT-cycle watchdog.
module jump_ctrl
    import jump_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic        is_branch,
    input  logic [2:0]  cmp_ctrl,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] imm,
    input  logic [31:0] pc,
    input  logic [4:0]  rd,
    output logic        fu_en,
    output logic        fu_jalr,
    output logic [2:0]  fu_cmp_ctrl,
    output logic [31:0] fu_rs1,
    output logic [31:0] fu_rs2,
    output logic [31:0] fu_imm,
    output logic [31:0] fu_pc,
    input  logic        fu_finish,
    input  logic        fu_cmp_res,
    input  logic [31:0] fu_pc_jump,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        busy,
    output logic        timeout_err
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic          r_jal;
    logic          r_jalr;
    logic          r_br;
    logic [2:0]    r_cmp;
    logic [31:0]   r_rs1;
    logic [31:0]   r_rs2;
    logic [31:0]   r_imm;
    logic [31:0]   r_pc;
    logic [4:0]    r_rd;
    logic [31:0]   r_target;
    logic          r_taken;
    logic          r_err;

    logic          w_hs;
    logic          w_fin;
    logic          w_tmo;

    assign w_hs  = issue_valid & (r_state == ST_IDLE);
    assign w_fin = fu_finish & (r_state == ST_WAIT);
    assign w_tmo = ~fu_finish & (r_state == ST_WAIT) & (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_hs) w_next = ST_SEND;
            ST_SEND: w_next = ST_WAIT;
            ST_WAIT: begin
                if (w_fin) begin
                    w_next = ST_DONE;
                end else if (w_tmo) begin
                    w_next = ST_IDLE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Class bits are decoded once at issue so jalr dominates every later use.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_jal    <= 1'b0;
            r_jalr   <= 1'b0;
            r_br     <= 1'b0;
            r_cmp    <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_imm    <= '0;
            r_pc     <= '0;
            r_rd     <= '0;
            r_target <= '0;
            r_taken  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_hs) begin
                r_jalr <= is_jalr;
                r_jal  <= is_jal & ~is_jalr;
                r_br   <= is_branch & ~is_jal & ~is_jalr;
                r_cmp  <= cmp_ctrl;
                r_rs1  <= rs1_data;
                r_rs2  <= rs2_data;
                r_imm  <= imm;
                r_pc   <= pc;
                r_rd   <= rd;
            end
            if (w_fin) begin
                r_target <= fu_pc_jump;
                r_taken  <= r_jal | r_jalr | (r_br & fu_cmp_res);
            end
            if (w_tmo) begin
                r_err <= 1'b1;
            end
            r_cnt <= (r_state == ST_WAIT) ? r_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        issue_ready    = (r_state == ST_IDLE);
        busy           = (r_state != ST_IDLE);
        fu_en          = (r_state == ST_SEND);
        fu_jalr        = r_jalr;
        fu_cmp_ctrl    = r_cmp;
        fu_rs1         = r_rs1;
        fu_rs2         = r_rs2;
        fu_imm         = r_imm;
        fu_pc          = r_pc;
        timeout_err    = r_err;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        flush          = 1'b0;
        wb_valid       = 1'b0;
        wb_rd          = '0;
        wb_data        = '0;
        if (r_state == ST_DONE) begin
            redirect_valid = r_taken;
            flush          = r_taken;
            redirect_pc    = r_jalr ? clr_bit0(r_target) : r_target;
            wb_valid       = (r_jal | r_jalr) & (r_rd != 5'd0);
            wb_rd          = r_rd;
            wb_data        = r_pc + 32'd4;
        end
    end

endmodule
